// File: rtl/wb_pkg.sv
// Shared constants for the writeback/commit stage: exception bit positions,
// ecodes, TLB op one-hot positions and the TLB write sequencing states.
package wb_pkg;

  localparam int TYPE_SYS  = 0;
  localparam int TYPE_BRK  = 1;
  localparam int TYPE_INE  = 2;
  localparam int TYPE_ALE  = 3;
  localparam int TYPE_ADEF = 4;
  localparam int TYPE_INT  = 5;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  // in_tlb_op is one-hot {srch, rd, wr, fill}
  localparam int TLB_OP_FILL = 0;
  localparam int TLB_OP_WR   = 1;
  localparam int TLB_OP_RD   = 2;
  localparam int TLB_OP_SRCH = 3;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_exc_prio.sv
// Priority encoder from the exception type vector to a single {ecode, esubcode}.
// Order: INT > ADEF > INE > BRK > SYS > ALE; esubcode is always zero.
module wb_exc_prio #(
  parameter int EXC_W = 6
) (
  input  logic [EXC_W-1:0] exc_i,
  output logic [5:0]       ecode_o,
  output logic [8:0]       esubcode_o
);
  import wb_pkg::*;

  // Select exactly one ecode, highest priority first.
  always_comb begin
    ecode_o    = ECODE_INT;
    esubcode_o = 9'h000;
    if (exc_i[TYPE_INT]) begin
      ecode_o = ECODE_INT;
    end else if (exc_i[TYPE_ADEF]) begin
      ecode_o = ECODE_ADE;
    end else if (exc_i[TYPE_INE]) begin
      ecode_o = ECODE_INE;
    end else if (exc_i[TYPE_BRK]) begin
      ecode_o = ECODE_BRK;
    end else if (exc_i[TYPE_SYS]) begin
      ecode_o = ECODE_SYS;
    end else if (exc_i[TYPE_ALE]) begin
      ecode_o = ECODE_ALE;
    end else begin
      ecode_o = ECODE_INT;
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// LoongArch writeback/commit stage: commits GPR/CSR/TLB side effects, raises
// exceptions and flushes with an epoch bit. Optional counters: WB_PERF_CNT_EN.
module wb_commit_stage #(
  parameter int DATA_W     = 32,
  parameter int TLB_IDX_W  = 4,
  parameter int EXC_W      = 6,
  parameter int TLB_WR_LAT = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 wb_allow_in,
  input  logic [DATA_W-1:0]    in_pc,
  input  logic [DATA_W-1:0]    in_result,
  input  logic                 in_gr_we,
  input  logic [4:0]           in_dest,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic                 in_ertn,
  input  logic                 in_refetch,
  input  logic                 in_epoch,
  input  logic                 in_csr_we,
  input  logic [13:0]          in_csr_num,
  input  logic [DATA_W-1:0]    in_csr_wmask,
  input  logic [DATA_W-1:0]    in_csr_wvalue,
  input  logic [3:0]           in_tlb_op,
  input  logic                 in_tlb_hit,
  input  logic [TLB_IDX_W-1:0] in_tlb_hit_idx,
  input  logic [TLB_IDX_W-1:0] csr_tlbidx_index,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [DATA_W-1:0]    debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic                 csr_we,
  output logic [13:0]          csr_num,
  output logic [DATA_W-1:0]    csr_wmask,
  output logic [DATA_W-1:0]    csr_wvalue,
  output logic                 wb_ex,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic [DATA_W-1:0]    wb_badvaddr,
  output logic [DATA_W-1:0]    wb_pc,
  output logic                 ertn_flush,
  output logic                 refetch_flush,
  output logic                 cur_epoch,
  output logic                 tlbsrch_we,
  output logic                 tlbrd_we,
  output logic                 tlb_we,
  output logic [TLB_IDX_W-1:0] tlb_w_index,
  output logic [TLB_IDX_W-1:0] tlb_r_index,
  output logic                 tlb_hit,
  output logic [TLB_IDX_W-1:0] tlb_hit_idx
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_retired,
  output logic [31:0]          perf_exc
`endif
);
  import wb_pkg::*;

  localparam int HOLD_W = (TLB_WR_LAT > 1) ? $clog2(TLB_WR_LAT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((TLB_WR_LAT > 0) ? TLB_WR_LAT - 1 : 0);

  logic                 valid_q;
  logic [DATA_W-1:0]    pc_q, result_q, csr_wmask_q, csr_wvalue_q;
  logic                 gr_we_q, ertn_q, refetch_q, epoch_q, csr_we_q, tlb_hit_q;
  logic [4:0]           dest_q;
  logic [EXC_W-1:0]     exc_q;
  logic [13:0]          csr_num_q;
  logic [3:0]           tlb_op_q;
  logic [TLB_IDX_W-1:0] tlb_hit_idx_q;

  logic                 cur_epoch_q, cur_epoch_d;
  logic [TLB_IDX_W-1:0] fill_ctr_q, fill_ctr_d;
  wb_state_e            state_q, state_d;
  logic [HOLD_W-1:0]    hold_ctr_q, hold_ctr_d;

  logic live_s, exc_any_s, tlb_wr_req_s, ready_go_s, commit_ok_s, flush_s;

  assign live_s       = valid_q & (epoch_q == cur_epoch_q);
  assign exc_any_s    = |exc_q;
  assign tlb_wr_req_s = live_s & ~exc_any_s & (tlb_op_q[TLB_OP_WR] | tlb_op_q[TLB_OP_FILL]);

  // TLB write sequencing: hold the instruction TLB_WR_LAT extra cycles.
  always_comb begin
    state_d    = state_q;
    hold_ctr_d = hold_ctr_q;
    ready_go_s = 1'b1;
    case (state_q)
      ST_RUN: begin
        if (tlb_wr_req_s && (TLB_WR_LAT > 0)) begin
          ready_go_s = 1'b0;
          hold_ctr_d = HOLD_LOAD;
          state_d    = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (hold_ctr_q == {HOLD_W{1'b0}}) begin
          state_d = ST_RUN;
        end else begin
          ready_go_s = 1'b0;
          hold_ctr_d = hold_ctr_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Side effects fire once, in the cycle the instruction actually retires.
  assign commit_ok_s = live_s & ready_go_s & ~exc_any_s;
  assign wb_ex       = live_s & exc_any_s;
  assign flush_s     = wb_ex | ertn_flush | refetch_flush;
  assign cur_epoch_d = cur_epoch_q ^ flush_s;
  assign fill_ctr_d  = fill_ctr_q + TLB_IDX_W'(1);
  assign wb_allow_in = ~valid_q | ready_go_s;

  // Control state: valid, epoch, TLBFILL counter, hold sequencer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q     <= 1'b0;
      cur_epoch_q <= 1'b0;
      fill_ctr_q  <= {TLB_IDX_W{1'b0}};
      state_q     <= ST_RUN;
      hold_ctr_q  <= {HOLD_W{1'b0}};
    end else begin
      if (wb_allow_in) valid_q <= in_valid;
      cur_epoch_q <= cur_epoch_d;
      fill_ctr_q  <= fill_ctr_d;
      state_q     <= state_d;
      hold_ctr_q  <= hold_ctr_d;
    end
  end

  // Instruction fields, captured on an accepted handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q          <= {DATA_W{1'b0}};
      result_q      <= {DATA_W{1'b0}};
      gr_we_q       <= 1'b0;
      dest_q        <= 5'd0;
      exc_q         <= {EXC_W{1'b0}};
      ertn_q        <= 1'b0;
      refetch_q     <= 1'b0;
      epoch_q       <= 1'b0;
      csr_we_q      <= 1'b0;
      csr_num_q     <= 14'd0;
      csr_wmask_q   <= {DATA_W{1'b0}};
      csr_wvalue_q  <= {DATA_W{1'b0}};
      tlb_op_q      <= 4'd0;
      tlb_hit_q     <= 1'b0;
      tlb_hit_idx_q <= {TLB_IDX_W{1'b0}};
    end else if (in_valid && wb_allow_in) begin
      pc_q          <= in_pc;
      result_q      <= in_result;
      gr_we_q       <= in_gr_we;
      dest_q        <= in_dest;
      exc_q         <= in_exc;
      ertn_q        <= in_ertn;
      refetch_q     <= in_refetch;
      epoch_q       <= in_epoch;
      csr_we_q      <= in_csr_we;
      csr_num_q     <= in_csr_num;
      csr_wmask_q   <= in_csr_wmask;
      csr_wvalue_q  <= in_csr_wvalue;
      tlb_op_q      <= in_tlb_op;
      tlb_hit_q     <= in_tlb_hit;
      tlb_hit_idx_q <= in_tlb_hit_idx;
    end
  end

  wb_exc_prio #(.EXC_W(EXC_W)) u_exc_prio (
    .exc_i      (exc_q),
    .ecode_o    (wb_ecode),
    .esubcode_o (wb_esubcode)
  );

  assign rf_we          = commit_ok_s & gr_we_q;
  assign rf_waddr       = dest_q;
  assign rf_wdata       = result_q;
  assign debug_wb_pc    = pc_q;
  assign debug_wb_rf_we = {4{rf_we}};
  assign csr_we         = commit_ok_s & csr_we_q;
  assign csr_num        = csr_num_q;
  assign csr_wmask      = csr_wmask_q;
  assign csr_wvalue     = csr_wvalue_q;
  assign wb_badvaddr    = result_q;
  assign wb_pc          = pc_q;
  assign ertn_flush     = commit_ok_s & ertn_q;
  assign refetch_flush  = commit_ok_s & refetch_q;
  assign cur_epoch      = cur_epoch_q;
  assign tlbsrch_we     = commit_ok_s & tlb_op_q[TLB_OP_SRCH];
  assign tlbrd_we       = commit_ok_s & tlb_op_q[TLB_OP_RD];
  assign tlb_we         = commit_ok_s & (tlb_op_q[TLB_OP_WR] | tlb_op_q[TLB_OP_FILL]);
  assign tlb_w_index    = tlb_op_q[TLB_OP_FILL] ? fill_ctr_q : csr_tlbidx_index;
  assign tlb_r_index    = csr_tlbidx_index;
  assign tlb_hit        = tlb_hit_q;
  assign tlb_hit_idx    = tlb_hit_idx_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_exc_q;

  // Retirement and exception event counters; both wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_retired_q <= 32'd0;
      perf_exc_q     <= 32'd0;
    end else begin
      if (commit_ok_s) perf_retired_q <= perf_retired_q + 32'd1;
      if (wb_ex) perf_exc_q <= perf_exc_q + 32'd1;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_exc     = perf_exc_q;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage with a 2-cycle TLB write hold.
module tb_wb_commit_stage;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, wb_allow_in;
  logic [31:0] in_pc, in_result, in_csr_wmask, in_csr_wvalue;
  logic        in_gr_we, in_ertn, in_refetch, in_epoch, in_csr_we, in_tlb_hit;
  logic [4:0]  in_dest;
  logic [5:0]  in_exc;
  logic [13:0] in_csr_num;
  logic [3:0]  in_tlb_op, in_tlb_hit_idx, csr_tlbidx_index;
  logic        rf_we, csr_we, wb_ex, ertn_flush, refetch_flush, cur_epoch;
  logic        tlbsrch_we, tlbrd_we, tlb_we, tlb_hit;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, debug_wb_pc, csr_wmask, csr_wvalue, wb_badvaddr, wb_pc;
  logic [3:0]  debug_wb_rf_we, tlb_w_index, tlb_r_index, tlb_hit_idx;
  logic [13:0] csr_num;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;

  wb_commit_stage #(.DATA_W(32), .TLB_IDX_W(4), .EXC_W(6), .TLB_WR_LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .wb_allow_in(wb_allow_in),
    .in_pc(in_pc), .in_result(in_result), .in_gr_we(in_gr_we), .in_dest(in_dest),
    .in_exc(in_exc), .in_ertn(in_ertn), .in_refetch(in_refetch), .in_epoch(in_epoch),
    .in_csr_we(in_csr_we), .in_csr_num(in_csr_num), .in_csr_wmask(in_csr_wmask),
    .in_csr_wvalue(in_csr_wvalue), .in_tlb_op(in_tlb_op), .in_tlb_hit(in_tlb_hit),
    .in_tlb_hit_idx(in_tlb_hit_idx), .csr_tlbidx_index(csr_tlbidx_index),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_badvaddr(wb_badvaddr), .wb_pc(wb_pc),
    .ertn_flush(ertn_flush), .refetch_flush(refetch_flush), .cur_epoch(cur_epoch),
    .tlbsrch_we(tlbsrch_we), .tlbrd_we(tlbrd_we), .tlb_we(tlb_we),
    .tlb_w_index(tlb_w_index), .tlb_r_index(tlb_r_index), .tlb_hit(tlb_hit),
    .tlb_hit_idx(tlb_hit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, result;
    logic        gr_we, ertn, refetch, epoch, csr_we;
    logic [4:0]  dest;
    logic [5:0]  exc;
    logic [3:0]  tlb_op, tlbidx;
  } txn_t;

  typedef struct {
    logic        rf_we, csr_we, ertn, refetch, ex, srch, rd, wr, fill;
    logic [4:0]  dest;
    logic [31:0] data, pc;
    logic [5:0]  ecode;
    logic [3:0]  tlbidx;
    int          stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        tb_epoch = 1'b0;
  logic [3:0]  m_fill = 4'd0;
  logic [3:0]  last_widx = 4'd0;

  // Reference TLBFILL counter: free-running from reset release.
  always @(posedge clk) begin
    if (!resetn) m_fill <= 4'd0;
    else m_fill <= m_fill + 4'd1;
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Exception bits: 0 SYS, 1 BRK, 2 INE, 3 ALE, 4 ADEF, 5 INT.
  function automatic logic [5:0] ref_ecode(input logic [5:0] x);
    if (x[5]) return 6'h00;
    if (x[4]) return 6'h08;
    if (x[2]) return 6'h0D;
    if (x[1]) return 6'h0C;
    if (x[0]) return 6'h0B;
    if (x[3]) return 6'h09;
    return 6'h00;
  endfunction

  function automatic txn_t base(input logic [31:0] pc);
    txn_t t;
    t.pc = pc; t.result = pc ^ 32'h5A5A_0000; t.gr_we = 1'b0; t.ertn = 1'b0;
    t.refetch = 1'b0; t.epoch = tb_epoch; t.csr_we = 1'b0; t.dest = 5'd0;
    t.exc = 6'd0; t.tlb_op = 4'd0; t.tlbidx = 4'd0;
    return t;
  endfunction

  function automatic exp_t model(input txn_t t);
    exp_t e;
    logic live, ok;
    live      = (t.epoch == tb_epoch);
    e.ex      = live && (t.exc != 6'd0);
    ok        = live && !e.ex;
    e.ecode   = ref_ecode(t.exc);
    e.rf_we   = ok && t.gr_we;
    e.csr_we  = ok && t.csr_we;
    e.ertn    = ok && t.ertn;
    e.refetch = ok && t.refetch;
    e.srch    = ok && t.tlb_op[3];
    e.rd      = ok && t.tlb_op[2];
    e.wr      = ok && (t.tlb_op[1] || t.tlb_op[0]);
    e.fill    = t.tlb_op[0];
    e.stalls  = e.wr ? LAT : 0;
    e.dest    = t.dest; e.data = t.result; e.pc = t.pc; e.tlbidx = t.tlbidx;
    return e;
  endfunction

  task automatic drive(input txn_t t);
    in_pc = t.pc; in_result = t.result; in_gr_we = t.gr_we; in_dest = t.dest;
    in_exc = t.exc; in_ertn = t.ertn; in_refetch = t.refetch; in_epoch = t.epoch;
    in_csr_we = t.csr_we; in_csr_num = 14'h0006; in_csr_wmask = 32'hFFFF_0000;
    in_csr_wvalue = t.result; in_tlb_op = t.tlb_op; in_tlb_hit = 1'b0;
    in_tlb_hit_idx = 4'd0; csr_tlbidx_index = t.tlbidx;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   stalls = 0;
    int   we_cnt = 0;
    bit   done = 0;
    e = exp_q.pop_front();
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (tlb_we) begin
        we_cnt++;
        last_widx = tlb_w_index;
        check_value({tag, "_widx"}, tlb_w_index, e.fill ? m_fill : e.tlbidx);
      end
      if (wb_allow_in) done = 1;
      else stalls++;
    end
    check_value({tag, "_done"}, done, 1'b1);
    check_value({tag, "_stalls"}, stalls, e.stalls);
    check_value({tag, "_tlb_we_cnt"}, we_cnt, e.wr ? 1 : 0);
    check_value({tag, "_rf_we"}, rf_we, e.rf_we);
    check_value({tag, "_dbg_rf_we"}, debug_wb_rf_we, {4{e.rf_we}});
    if (e.rf_we) begin
      check_value({tag, "_rf_waddr"}, rf_waddr, e.dest);
      check_value({tag, "_rf_wdata"}, rf_wdata, e.data);
    end
    check_value({tag, "_csr_we"}, csr_we, e.csr_we);
    check_value({tag, "_ertn"}, ertn_flush, e.ertn);
    check_value({tag, "_refetch"}, refetch_flush, e.refetch);
    check_value({tag, "_wb_ex"}, wb_ex, e.ex);
    if (e.ex) begin
      check_value({tag, "_ecode"}, wb_ecode, e.ecode);
      check_value({tag, "_badv"}, wb_badvaddr, e.data);
      check_value({tag, "_wb_pc"}, wb_pc, e.pc);
    end
    check_value({tag, "_esub"}, wb_esubcode, 9'd0);
    check_value({tag, "_srch"}, tlbsrch_we, e.srch);
    check_value({tag, "_rd"}, tlbrd_we, e.rd);
    check_value({tag, "_epoch"}, cur_epoch, tb_epoch);
    if (e.ex || e.ertn || e.refetch) tb_epoch = ~tb_epoch;
  endtask

  task automatic send(input string tag, input txn_t t);
    bit acc = 0;
    exp_q.push_back(model(t));
    @(posedge clk); #1;
    drive(t);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = wb_allow_in;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc) begin
      drain(tag);
    end else begin
      check_value({tag, "_accept"}, 1'b0, 1'b1);
      void'(exp_q.pop_front());
    end
  endtask

  txn_t t;
  logic [5:0] pats [5] = '{6'b010100, 6'b000110, 6'b001011, 6'b001001, 6'b001000};

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0;
    drive(base(32'h0));
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_value("rst_allow_in", wb_allow_in, 1'b1);
    check_value("rst_rf_we", rf_we, 1'b0);
    check_value("rst_wb_ex", wb_ex, 1'b0);
    check_value("rst_tlb_we", tlb_we, 1'b0);
    check_value("rst_epoch", cur_epoch, 1'b0);
    check_value("rst_pc", debug_wb_pc, 32'd0);

    t = base(32'h1C00_0000); t.gr_we = 1'b1; t.dest = 5'd3; t.result = 32'h1234;
    send("alu", t);

    t = base(32'h1C00_0004); t.gr_we = 1'b1; t.dest = 5'd7; t.exc = 6'b100001;
    send("int_sys", t);
    @(negedge clk);
    check_value("epoch_after_ex", cur_epoch, 1'b1);

    t = base(32'h1C00_0008); t.epoch = 1'b0; t.gr_we = 1'b1; t.dest = 5'd5; t.csr_we = 1'b1;
    send("stale", t);
    t = base(32'h1C00_0010); t.gr_we = 1'b1; t.dest = 5'd5; t.result = 32'hCAFE;
    send("after_stale", t);

    for (int i = 0; i < 5; i++) begin
      t = base(32'h1C00_0100 + 32'(i * 4)); t.gr_we = 1'b1; t.dest = 5'd9; t.exc = pats[i];
      send($sformatf("prio%0d", i), t);
    end

    t = base(32'h1C00_0200); t.ertn = 1'b1; t.csr_we = 1'b1;
    send("ertn_csr", t);
    t = base(32'h1C00_0204); t.ertn = 1'b1; t.exc = 6'b010000;
    send("ertn_adef", t);
    t = base(32'h1C00_0208); t.refetch = 1'b1; t.gr_we = 1'b1; t.dest = 5'd1;
    send("refetch", t);

    t = base(32'h1C00_0300); t.tlb_op = 4'b0010; t.tlbidx = 4'd3;
    send("tlbwr", t);
    t = base(32'h1C00_0304); t.tlb_op = 4'b1000;
    send("tlbsrch", t);
    t = base(32'h1C00_0308); t.tlb_op = 4'b0100;
    send("tlbrd", t);
    t = base(32'h1C00_030C); t.tlb_op = 4'b0010; t.exc = 6'b000100;
    send("tlbwr_ex", t);

    for (int i = 0; i < 20 && m_fill != 4'd11; i++) @(negedge clk);
    t = base(32'h1C00_0400); t.tlb_op = 4'b0001; t.tlbidx = 4'd2;
    send("tlbfill", t);
    check_value("fill_idx15", last_widx, 4'hF);
    @(negedge clk);
    check_value("fill_wrap_idx", tlb_w_index, 4'h0);
    check_value("fill_wrap_we", tlb_we, 1'b0);

    // Reset while a TLBWR is being held.
    @(posedge clk); #1;
    t = base(32'h1C00_0500); t.tlb_op = 4'b0010; t.tlbidx = 4'd6;
    drive(t);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_value("hold_c0_allow", wb_allow_in, 1'b0);
    check_value("hold_c0_we", tlb_we, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    check_value("hold_rst_we", tlb_we, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tb_epoch = 1'b0;
    @(negedge clk);
    check_value("post_rst_we", tlb_we, 1'b0);
    check_value("post_rst_allow", wb_allow_in, 1'b1);
    check_value("post_rst_rf_we", rf_we, 1'b0);
    check_value("post_rst_epoch", cur_epoch, 1'b0);

    t = base(32'h1C00_0600); t.gr_we = 1'b1; t.dest = 5'd12; t.result = 32'hBEEF;
    send("post_rst_alu", t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Parametrised writeback/commit stage for the LoongArch pipeline; last stage after MEM.
- Registers one instruction, commits register-file writes and CSR writes, and raises exceptions with priority-encoded ecodes.
- Sequences TLB write ops over a configurable stall, and generates the TLBFILL index.
- Suppresses all side effects of wrong-path instructions after a flush, using an epoch bit.

Parameters:
- DATA_W, 32, datapath/PC width.
- TLB_IDX_W, 4, TLB index width (entries = 2**TLB_IDX_W).
- EXC_W, 6, width of exception type vector.
- TLB_WR_LAT, 1, extra cycles WB holds a TLBWR/TLBFILL (0 = no stall).

Ports:
- Clock/reset:
  - clk in 1 clock
  - resetn in 1 synchronous active-low reset
- Upstream handshake:
  - in_valid in 1 MEM has an instruction
  - wb_allow_in out 1 WB can accept
- Instruction fields:
  - in_pc in DATA_W instruction PC
  - in_result in DATA_W final result / bad vaddr
  - in_gr_we in 1 GPR write
  - in_dest in 5 GPR index
  - in_exc in EXC_W exception type vector
  - in_ertn in 1 ERTN
  - in_refetch in 1 refetch after commit
  - in_epoch in 1 epoch tag of instruction
  - in_csr_we in 1 CSR write
  - in_csr_num in 14 CSR number
  - in_csr_wmask in DATA_W CSR mask
  - in_csr_wvalue in DATA_W CSR value
  - in_tlb_op in 4 one-hot {srch,rd,wr,fill}
  - in_tlb_hit in 1 TLBSRCH hit
  - in_tlb_hit_idx in TLB_IDX_W TLBSRCH index
- CSR input:
  - csr_tlbidx_index in TLB_IDX_W TLBIDX.index
- Register file / debug:
  - rf_we out 1 GPR write enable
  - rf_waddr out 5 GPR write address
  - rf_wdata out DATA_W GPR write data
  - debug_wb_pc out DATA_W PC
  - debug_wb_rf_we out 4 replicated rf_we
- CSR write:
  - csr_we out 1 CSR write enable
  - csr_num out 14 CSR number
  - csr_wmask out DATA_W CSR mask
  - csr_wvalue out DATA_W CSR value
- Exception / flush:
  - wb_ex out 1 exception commit
  - wb_ecode out 6 ecode
  - wb_esubcode out 9 esubcode
  - wb_badvaddr out DATA_W bad address
  - wb_pc out DATA_W exception PC
  - ertn_flush out 1 ERTN commit
  - refetch_flush out 1 refetch commit
  - cur_epoch out 1 current epoch, sent to IF
- TLB:
  - tlbsrch_we out 1 TLBSRCH commit
  - tlbrd_we out 1 TLBRD commit
  - tlb_we out 1 TLBWR/TLBFILL write strobe
  - tlb_w_index out TLB_IDX_W write index
  - tlb_r_index out TLB_IDX_W read index
  - tlb_hit out 1 TLBSRCH hit
  - tlb_hit_idx out TLB_IDX_W TLBSRCH index

Behaviour:
- Reset:
  - WB_valid=0, cur_epoch=0, fill_ctr=0, FSM=RUN.
  - All strobes 0; data outputs 0 (registered fields cleared).
- Handshake:
  - wb_allow_in = ~WB_valid | ready_go.
  - Fields latch when in_valid & wb_allow_in.
  - WB_valid <= in_valid whenever wb_allow_in.
- live = WB_valid & (in_epoch_r == cur_epoch). A stale instruction (epoch mismatch) retires silently: every strobe is 0 and it takes no stall.
- Exception:
  - wb_ex = live & |exc_r.
  - ecode priority: INT > ADEF > INE > BRK > SYS > ALE. Exactly one ecode, never an OR of several.
  - esubcode = 0 for every type.
  - wb_badvaddr = result_r.
- Side-effect gating:
  - rf_we = live & gr_we_r & ~wb_ex.
  - csr_we = live & csr_we_r & ~wb_ex.
  - ertn_flush = live & ertn_r & ~wb_ex.
  - refetch_flush = live & refetch_r & ~wb_ex.
  - TLB strobes are all gated by live & ~wb_ex.
- Epoch:
  - cur_epoch toggles in the cycle wb_ex | ertn_flush | refetch_flush is high; each flush toggles once.
  - Upstream tags fetches with cur_epoch.
- TLB FSM (RUN, HOLD):
  - RUN, live TLBWR/TLBFILL, TLB_WR_LAT>0: ready_go=0, load hold_ctr=TLB_WR_LAT-1, go to HOLD.
  - HOLD: decrement hold_ctr. At 0, ready_go=1 and return to RUN.
  - tlb_we pulses exactly once, in the final (ready_go=1) cycle.
  - TLB_WR_LAT=0: single-cycle, no HOLD.
  - tlb_w_index = csr_tlbidx_index for WR, fill_ctr for FILL.
  - fill_ctr free-runs +1 per cycle, wraps at all-ones to 0. It is sampled in the strobe cycle.
  - tlb_r_index = csr_tlbidx_index.
  - tlbsrch_we, tlbrd_we: single-cycle, no stall.
- Simultaneous events:
  - Exception on a TLB op: no stall, no tlb_we.
  - Stale instruction in HOLD is impossible: entry requires live.
  - Reset mid-HOLD returns to RUN with no tlb_we.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- With the macro, add two outputs:
  - perf_retired [31:0]: +1 per live non-exception commit.
  - perf_exc [31:0]: +1 per wb_ex.
  - Both wrap, and reset to 0.
- Without the macro, the ports and counters are absent.

Decomposition:
- Package wb_pkg holds:
  - exception bit positions TYPE_SYS..TYPE_INT;
  - ecode constants ECODE_INT=0x00, ADE=0x08, ALE=0x09, SYS=0x0B, BRK=0x0C, INE=0x0D;
  - TLB op one-hot positions;
  - FSM state enum.
- One sub-module, wb_exc_prio: combinational priority encoder from exc vector to {ecode, esubcode}.

Test Plan:
- Exception priority: in_exc with INT|SYS bits set, gr_we=1 -> wb_ex=1, ecode=0x00, rf_we=0, cur_epoch 0->1.
- Stale instruction: after the flush, an instruction with epoch=0, gr_we=1, dest=5 -> rf_we=0, csr_we=0; next instruction with epoch=1 writes dest=5.
- TLBWR stall: TLBWR, TLB_WR_LAT=2, csr_tlbidx_index=3 -> wb_allow_in low 2 cycles, one tlb_we pulse with tlb_w_index=3.
- TLBFILL index: TLBFILL committing when fill_ctr=15 -> tlb_w_index=15; fill_ctr=0 next cycle.
- ERTN with CSR write: ertn=1, csr_we=1 -> ertn_flush=1, csr_we=1, epoch toggles; ERTN carrying ADEF -> wb_ex=1, ecode=0x08, ertn_flush=0.
- Reset mid-HOLD: resetn=0 during HOLD -> no tlb_we; all strobes 0; wb_allow_in=1 next cycle.
